// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a rotating one-hot token and a hold-time limit per grant.
// Optional RING_ARB_LOCK_EN adds a lock input that suppresses the hold timeout.
module ring_rr_arbiter #(
  parameter int unsigned NUM_REQ  = 8,
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned ID_W     = $clog2(NUM_REQ)
) (
  input  logic               clock0,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               dir,
`ifdef RING_ARB_LOCK_EN
  input  logic               lock,
`endif
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               busy,
  output logic [NUM_REQ-1:0] token
);

  localparam int unsigned HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int unsigned CW = ID_W + 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state, state_nx;
  logic [HW-1:0]      hold_cnt, hold_cnt_nx;
  logic [ID_W-1:0]    tok_id, tok_id_nx;
  logic [NUM_REQ-1:0] grant_nx, token_nx;
  logic [ID_W-1:0]    grant_id_nx;
  logic               busy_nx;
  logic               lock_c;
  logic               arb_c;
  logic               found_c;
  logic [ID_W-1:0]    win_c;
  logic [CW-1:0]      cand_c;

`ifdef RING_ARB_LOCK_EN
  assign lock_c = lock;
`else
  assign lock_c = 1'b0;
`endif

  // First requester after the token position, walking in the selected direction.
  always_comb begin
    found_c = 1'b0;
    win_c   = '0;
    cand_c  = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      if (dir) cand_c = {1'b0, tok_id} + CW'(i);
      else     cand_c = {1'b0, tok_id} + CW'(NUM_REQ - i);
      if (cand_c >= CW'(NUM_REQ)) cand_c = cand_c - CW'(NUM_REQ);
      if (!found_c && req[cand_c[ID_W-1:0]]) begin
        found_c = 1'b1;
        win_c   = cand_c[ID_W-1:0];
      end
    end
  end

  always_ff @(posedge clock0) begin
    if (reset) begin
      state    <= IDLE;
      hold_cnt <= '0;
      tok_id   <= ID_W'(NUM_REQ - 1);
      token    <= {1'b1, {(NUM_REQ-1){1'b0}}};
      grant    <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      hold_cnt <= hold_cnt_nx;
      tok_id   <= tok_id_nx;
      token    <= token_nx;
      grant    <= grant_nx;
      grant_id <= grant_id_nx;
      busy     <= busy_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    hold_cnt_nx = hold_cnt;
    tok_id_nx   = tok_id;
    token_nx    = token;
    grant_nx    = grant;
    grant_id_nx = grant_id;
    busy_nx     = busy;
    arb_c       = 1'b0;

    case (state)
      IDLE: arb_c = |req;
      BUSY: begin
        if (!req[grant_id]) begin
          arb_c = 1'b1;
        end else if (hold_cnt == HW'(MAX_HOLD - 1)) begin
          // Saturated count: lock keeps the holder, otherwise time out.
          arb_c = !lock_c;
        end else begin
          hold_cnt_nx = hold_cnt + HW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase

    if (arb_c) begin
      hold_cnt_nx = '0;
      if (found_c) begin
        state_nx    = BUSY;
        grant_nx    = NUM_REQ'(1) << win_c;
        grant_id_nx = win_c;
        token_nx    = NUM_REQ'(1) << win_c;
        tok_id_nx   = win_c;
        busy_nx     = 1'b1;
      end else begin
        state_nx    = IDLE;
        grant_nx    = '0;
        grant_id_nx = '0;
        busy_nx     = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Directed and random checks of ring_rr_arbiter against a behavioural model.
module tb_ring_rr_arbiter;

  localparam int N  = 8;
  localparam int MH = 4;

  logic         clock0 = 1'b0;
  logic         reset  = 1'b1;
  logic [N-1:0] req    = '0;
  logic         dir    = 1'b1;
  logic         lock   = 1'b0;
  logic [N-1:0] grant;
  logic [2:0]   grant_id;
  logic         busy;
  logic [N-1:0] token;

  int total  = 0;
  int passed = 0;

  // Reference model state: plain integer indices.
  int m_tok  = N - 1;
  int m_g    = 0;
  int m_hold = 0;
  bit m_busy = 0;

  ring_rr_arbiter #(.NUM_REQ(N), .MAX_HOLD(MH)) dut (
    .clock0   (clock0),
    .reset    (reset),
    .req      (req),
    .dir      (dir),
`ifdef RING_ARB_LOCK_EN
    .lock     (lock),
`endif
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .token    (token)
  );

  always #5 clock0 = ~clock0;

  function automatic int pick(input logic [N-1:0] r, input bit d, input int t);
    for (int i = 1; i <= N; i++) begin
      int c;
      c = d ? (t + i) % N : (t - i + N) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_step(input bit rst, input logic [N-1:0] r, input bit d, input bit lk);
    bit arb;
    int w;
    if (rst) begin
      m_busy = 0; m_g = 0; m_tok = N - 1; m_hold = 0;
      return;
    end
    arb = 0;
    if (!m_busy)                arb = (r != 0);
    else if (!r[m_g])           arb = 1;
    else if (m_hold == MH - 1) begin
`ifdef RING_ARB_LOCK_EN
      arb = !lk;
`else
      arb = 1;
`endif
    end else                    m_hold++;
    if (arb) begin
      w = pick(r, d, m_tok);
      m_hold = 0;
      if (w >= 0) begin m_busy = 1; m_g = w; m_tok = w; end
      else begin m_busy = 0; m_g = 0; end
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_model();
    logic [N-1:0] eg;
    eg = m_busy ? N'(1) << m_g : '0;
    check("grant", 64'(grant), 64'(eg));
    check("grant_id", 64'(grant_id), 64'(m_g));
    check("busy", 64'(busy), 64'(m_busy));
    check("token", 64'(token), 64'(N'(1) << m_tok));
  endtask

  // One clock: drive inputs, advance model, sample after the edge.
  task automatic cyc(input bit rst, input logic [N-1:0] r, input bit d, input bit lk);
    @(negedge clock0);
    reset = rst; req = r; dir = d; lock = lk;
    @(posedge clock0);
    model_step(rst, r, d, lk);
    #1;
    check_model();
  endtask

  initial begin
    logic [N-1:0] exp_seq [16];

    // 1: reset state, then single requester 0
    cyc(1, 8'h00, 1, 0);
    check("rst_grant", 64'(grant), 64'h0);
    check("rst_token", 64'(token), 64'h80);
    check("rst_busy", 64'(busy), 64'h0);
    cyc(0, 8'h00, 1, 0);
    check("idle_grant", 64'(grant), 64'h0);
    cyc(0, 8'h01, 1, 0);
    check("t1_grant", 64'(grant), 64'h01);
    check("t1_token", 64'(token), 64'h01);
    check("t1_busy", 64'(busy), 64'h1);

    // 2: two requesters alternate every MAX_HOLD cycles
    cyc(1, 8'h00, 1, 0);
    for (int i = 0; i < 16; i++) exp_seq[i] = ((i / 4) % 2 == 0) ? 8'h01 : 8'h80;
    for (int i = 0; i < 16; i++) begin
      cyc(0, 8'h81, 1, 0);
      check("t2_alt", 64'(grant), 64'(exp_seq[i]));
    end

    // 3: descending search from reset token
    cyc(1, 8'h00, 0, 0);
    cyc(0, 8'h41, 0, 0);
    check("t3_grant", 64'(grant), 64'h40);
    check("t3_token", 64'(token), 64'h40);

    // 4: lone requester re-granted across timeouts
    cyc(1, 8'h00, 1, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 8'h08, 1, 0);
      check("t4_grant", 64'(grant), 64'h08);
      check("t4_busy", 64'(busy), 64'h1);
    end

    // 5: release hands off without a gap, then goes idle
    cyc(1, 8'h00, 1, 0);
    cyc(0, 8'h04, 1, 0);
    check("t5_g2", 64'(grant), 64'h04);
    cyc(0, 8'h24, 1, 0);
    cyc(0, 8'h20, 1, 0);
    check("t5_handoff", 64'(grant), 64'h20);
    cyc(0, 8'h00, 1, 0);
    check("t5_idle_grant", 64'(grant), 64'h0);
    check("t5_idle_busy", 64'(busy), 64'h0);

    // 6: reset mid-grant
    cyc(1, 8'h00, 1, 0);
    cyc(0, 8'h10, 1, 0);
    check("t6_g4", 64'(grant), 64'h10);
    cyc(1, 8'h10, 1, 0);
    check("t6_grant", 64'(grant), 64'h0);
    check("t6_id", 64'(grant_id), 64'h0);
    check("t6_token", 64'(token), 64'h80);

`ifdef RING_ARB_LOCK_EN
    cyc(0, 8'h11, 1, 1);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 8'h11, 1, 1);
      check("lock_hold", 64'(grant), 64'h01);
    end
    cyc(0, 8'h11, 1, 0);
    check("lock_release", 64'(grant), 64'h10);
`endif

    // Random traffic with occasional reset
    cyc(1, 8'h00, 1, 0);
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] r;
      r = N'($urandom) & N'($urandom);
      if ($urandom_range(0, 9) == 0) r = '0;
      cyc($urandom_range(0, 59) == 0, r, 1'($urandom), 1'($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ring_rr_arbiter.md
Name: ring_rr_arbiter

Overview:
- Round-robin arbiter that shares one resource (a ring-counter shift datapath) among NUM_REQ requesters.
- A one-hot token register rotates around the requester ring in a selectable direction. This mirrors the left/right ring shift.
- The token records the last grantee, which has the lowest priority at the next arbitration.
- A hold counter limits how long any grantee can keep the resource.

Parameters:
- NUM_REQ, 8, number of requesters; legal range 2..64.
- MAX_HOLD, 4, maximum consecutive cycles one grant is held before forced re-arbitration; must be >= 1.
- ID_W, $clog2(NUM_REQ), width of grant_id (derived; not overridden).

Ports:
- clock0  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  request vector, one bit per requester; level-sensitive.
- dir  input  1  search direction. 1 = ascending index (left), 0 = descending index (right). Sampled only at arbitration edges.
- grant  output  NUM_REQ  registered one-hot grant; all-zero when idle.
- grant_id  output  ID_W  binary index of the current grantee; 0 when idle.
- busy  output  1  high while any grant is active.
- token  output  NUM_REQ  one-hot round-robin pointer (index of the last grantee).

Behaviour:
- Reset: reset is synchronous, active-high on clock0. On the edge where reset is high:
  - grant = 0, grant_id = 0, busy = 0.
  - token = 1 << (NUM_REQ-1) (MSB set).
  - state = IDLE, hold_cnt = 0.
  - Reset has priority over every other event, including mid-grant.
- Priority order, with t = index of the set token bit:
  - dir=1: t+1, t+2, ..., wrapping modulo NUM_REQ, ending at t.
  - dir=0: t-1, t-2, ..., wrapping, ending at t.
  - Winner = first requester in that order with req high.
- FSM has two states, IDLE and BUSY.
- IDLE:
  - req == 0: stay IDLE; outputs unchanged (grant 0).
  - req != 0: on the next edge, grant = onehot(winner), grant_id = winner, token = onehot(winner), busy = 1, hold_cnt = 0, state = BUSY.
  - Latency: req asserted in cycle n gives grant visible in cycle n+1.
- BUSY, with g = current grantee:
  - req[g] high and hold_cnt < MAX_HOLD-1: keep grant; hold_cnt++.
  - req[g] high and hold_cnt == MAX_HOLD-1 (timeout): re-arbitrate on this edge.
    - g is lowest priority because token = g.
    - If g is the only requester, g is re-granted with hold_cnt = 0; grant has no gap.
  - req[g] low (release): re-arbitrate on this edge. If another req is pending, the new grant appears the next cycle with no idle cycle. If none is pending, grant = 0, busy = 0, state = IDLE.
- Every arbitration edge loads token with the new winner. Token is never all-zero and never multi-hot.
- A grant cannot be withdrawn by other requesters; only release, timeout or reset end it.
- req bits changing mid-grant (other than req[g]) have no effect until the next arbitration edge.
- A dir change mid-grant takes effect at the next arbitration edge only.
- MAX_HOLD=1: arbitration occurs every cycle while busy.

Optional Feature:
- Macro: RING_ARB_LOCK_EN
- Defined: adds input port lock (1 bit).
  - While lock is high in BUSY and req[g] is high, the timeout is suppressed. hold_cnt saturates at MAX_HOLD-1 and the grant stays on g.
  - When lock deasserts with hold_cnt saturated, re-arbitration occurs on the next edge.
  - lock is ignored in IDLE.
- Undefined: no lock port; timeout always applies.

Test Plan (NUM_REQ=8, MAX_HOLD=4):
1. Reset, then dir=1, req=8'h01 -> grant=8'h01, grant_id=0, busy=1 one cycle after req; token=8'h01.
2. Reset, dir=1, req=8'h81 held -> grant 8'h01 for 4 cycles, then 8'h80 for 4 cycles, alternating with no gap cycles.
3. Reset, dir=0, req=8'h41 -> grant=8'h40 (order 6,5,...,0,7); token=8'h40.
4. Only req[3] held for 10 cycles -> grant=8'h08 continuously; hold_cnt restarts at each 4-cycle timeout; busy never drops.
5. Grant on bit 2, req=8'h24, then req[2] drops -> next cycle grant=8'h20 with no idle cycle. Then req=0 -> grant=0, busy=0, state IDLE.
6. Reset asserted while busy with grant=8'h10 -> next cycle grant=0, grant_id=0, busy=0, token=8'h80. With RING_ARB_LOCK_EN and lock=1, the holder keeps the grant past 4 cycles until lock drops.
